muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the same register-file operands as the ALU and owns the architectural HI/LO registers.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. The controller stalls the core on busy_md_o.
- hi_md_o/lo_md_o feed the write-back mux alongside the ALU result for MFHI/MFLO.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv.sv | 164 ++++++++++++++++
 tb/tb_muldiv.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute-stage controller and the muldiv unit.
// Signal names match the original muldiv port names.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] opr_a_md_i;
  logic [XLEN-1:0] opr_b_md_i;
  logic [2:0]      op_md_i;
  logic            start_md_i;
  logic            busy_md_o;
  logic            done_md_o;
  logic [XLEN-1:0] hi_md_o;
  logic [XLEN-1:0] lo_md_o;

  modport master (
    output opr_a_md_i, opr_b_md_i, op_md_i, start_md_i,
    input  busy_md_o, done_md_o, hi_md_o, lo_md_o
  );

  modport slave (
    input  opr_a_md_i, opr_b_md_i, op_md_i, start_md_i,
    output busy_md_o, done_md_o, hi_md_o, lo_md_o
  );
endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, 34-cycle latency.
// Optional MULDIV_DIV0_FLAG_EN adds a sticky divide-by-zero flag output div0_md_o.
module muldiv #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic     div0_md_o
`endif
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  state_e            state_q, state_d;
  logic              is_div_q, is_signed_q, neg_res_q, neg_rem_q, b_zero_q;
  logic [XLEN-1:0]   opa_q, opb_q, orig_a_q, hi_q, lo_q;
  logic [2*XLEN-1:0] acc_q;
  logic [5:0]        cnt_q;
  logic              done_q;
  logic              accept;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_ext;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && md.start_md_i;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !md.op_md_i[2]) state_d = PREP;
      PREP: state_d = CALC;
      CALC: if (cnt_q == 6'(ITER - 1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    md.busy_md_o = (state_q != IDLE);
    md.done_md_o = done_q;
    md.hi_md_o   = hi_q;
    md.lo_md_o   = lo_q;
  end

  // Multiply keeps the running product in acc and shifts it right; divide keeps
  // remainder in acc[hi] and shifts quotient bits into acc[lo] while opa shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    div_ext  = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
    div_ge   = div_ext >= {1'b0, opb_q};
    div_diff = XLEN'(div_ext - {1'b0, opb_q});
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      b_zero_q    <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      orig_a_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            case (md.op_md_i)
              MD_MTHI: hi_q <= md.opr_a_md_i;
              MD_MTLO: lo_q <= md.opr_a_md_i;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div_q    <= md.op_md_i[1];
                is_signed_q <= !md.op_md_i[0];
                opa_q       <= md.opr_a_md_i;
                opb_q       <= md.opr_b_md_i;
                orig_a_q    <= md.opr_a_md_i;
              end
              default: ;
            endcase
          end
        end
        PREP: begin
          if (is_signed_q) begin
            opa_q <= opa_q[XLEN-1] ? -opa_q : opa_q;
            opb_q <= opb_q[XLEN-1] ? -opb_q : opb_q;
          end
          neg_res_q <= is_signed_q && (opa_q[XLEN-1] ^ opb_q[XLEN-1]);
          neg_rem_q <= is_signed_q && opa_q[XLEN-1];
          b_zero_q  <= (opb_q == '0);
          acc_q     <= '0;
          cnt_q     <= '0;
        end
        CALC: begin
          if (!is_div_q) begin
            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
            opb_q <= opb_q >> 1;
          end else begin
            acc_q[2*XLEN-1:XLEN] <= div_ge ? div_diff : div_ext[XLEN-1:0];
            acc_q[XLEN-1:0]      <= {acc_q[XLEN-2:0], div_ge};
            opa_q                <= opa_q << 1;
          end
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end else if (b_zero_q) begin
            hi_q <= orig_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic div0_q;

  always_ff @(posedge clk) begin
    if (reset)                                       div0_q <= 1'b0;
    else if (accept)                                 div0_q <= 1'b0;
    else if (state_q == FIX && is_div_q && b_zero_q) div0_q <= 1'b1;
  end

  assign div0_md_o = div0_q;
`endif

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv: MTHI/MTLO, signed/unsigned mul/div,
// divide-by-zero, overflow, reset abort and back-to-back timing.
module tb_muldiv;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  muldiv_if md_bus ();

`ifdef MULDIV_DIV0_FLAG_EN
  logic div0;
  muldiv dut (.clk(clk), .reset(reset), .md(md_bus), .div0_md_o(div0));
`else
  muldiv dut (.clk(clk), .reset(reset), .md(md_bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge with the unit idle (or in a done cycle); returns at the
  // negedge of the done cycle.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo);
    int n;
    md_bus.op_md_i    = op;
    md_bus.opr_a_md_i = a;
    md_bus.opr_b_md_i = b;
    md_bus.start_md_i = 1'b1;
    @(negedge clk);
    md_bus.start_md_i = 1'b0;
    md_bus.opr_a_md_i = 32'hDEADBEEF;
    md_bus.opr_b_md_i = 32'h0BADF00D;
`ifdef MULDIV_DIV0_FLAG_EN
    chk({tag, ".div0_clr"}, 32'(div0), 32'd0);
`endif
    n = 0;
    while (md_bus.busy_md_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, n, 32'd34);
    chk({tag, ".done"}, 32'(md_bus.done_md_o), 32'd1);
    chk({tag, ".hi"}, md_bus.hi_md_o, exp_hi);
    chk({tag, ".lo"}, md_bus.lo_md_o, exp_lo);
`ifdef MULDIV_DIV0_FLAG_EN
    chk({tag, ".div0"}, 32'(div0), 32'((op[1] == 1'b1) && (b == 32'd0)));
`endif
  endtask

  initial begin
    int   seen;
    int   t1;
    int   t2;
    passed = 0;
    total  = 0;
    md_bus.start_md_i = 1'b0;
    md_bus.op_md_i    = 3'b110;
    md_bus.opr_a_md_i = '0;
    md_bus.opr_b_md_i = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.hi", md_bus.hi_md_o, 32'd0);
    chk("rst.lo", md_bus.lo_md_o, 32'd0);
    chk("rst.busy", 32'(md_bus.busy_md_o), 32'd0);
    chk("rst.done", 32'(md_bus.done_md_o), 32'd0);

    md_bus.op_md_i = 3'b100; md_bus.opr_a_md_i = 32'h12345678; md_bus.start_md_i = 1'b1;
    @(negedge clk);
    md_bus.op_md_i = 3'b101; md_bus.opr_a_md_i = 32'h9ABCDEF0;
    chk("mthi.hi", md_bus.hi_md_o, 32'h12345678);
    chk("mthi.busy", 32'(md_bus.busy_md_o), 32'd0);
    @(negedge clk);
    md_bus.start_md_i = 1'b0;
    chk("mtlo.lo", md_bus.lo_md_o, 32'h9ABCDEF0);
    chk("mtlo.hi", md_bus.hi_md_o, 32'h12345678);
    chk("mtlo.busy", 32'(md_bus.busy_md_o), 32'd0);
    chk("mtlo.done", 32'(md_bus.done_md_o), 32'd0);

    md_bus.op_md_i = 3'b110; md_bus.opr_a_md_i = 32'h55555555; md_bus.start_md_i = 1'b1;
    @(negedge clk);
    md_bus.start_md_i = 1'b0;
    @(negedge clk);
    chk("noop.busy", 32'(md_bus.busy_md_o), 32'd0);
    chk("noop.hi", md_bus.hi_md_o, 32'h12345678);
    chk("noop.lo", md_bus.lo_md_o, 32'h9ABCDEF0);

    run("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(negedge clk);
    chk("mult_neg.done_pulse", 32'(md_bus.done_md_o), 32'd0);
    chk("mult_neg.hi_hold", md_bus.hi_md_o, 32'hFFFFFFFF);
    run("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run("divu_zero", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    @(negedge clk);
`ifdef MULDIV_DIV0_FLAG_EN
    chk("div0.sticky", 32'(div0), 32'd1);
`endif
    run("div_zero", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run("mult_mix", 3'b000, 32'h00012345, 32'hFFFFF000, 32'hFFFFFFFF, 32'hEDCBB000);

    // Abort: MULT, ignored DIV start at cycle 10, synchronous reset at cycle 20.
    @(negedge clk);
    md_bus.op_md_i = 3'b000; md_bus.opr_a_md_i = 32'd5; md_bus.opr_b_md_i = 32'd5;
    md_bus.start_md_i = 1'b1;
    @(negedge clk);
    md_bus.start_md_i = 1'b0;
    repeat (8) @(negedge clk);
    md_bus.op_md_i = 3'b010; md_bus.opr_a_md_i = 32'd9; md_bus.opr_b_md_i = 32'd3;
    md_bus.start_md_i = 1'b1;
    @(negedge clk);
    md_bus.start_md_i = 1'b0;
    chk("abort.busy_mid", 32'(md_bus.busy_md_o), 32'd1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", 32'(md_bus.busy_md_o), 32'd0);
    chk("abort.hi", md_bus.hi_md_o, 32'd0);
    chk("abort.lo", md_bus.lo_md_o, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_bus.done_md_o !== 1'b0 || md_bus.busy_md_o !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("abort.no_done", seen, 32'd0);
    run("multu_after", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    @(negedge clk);
    run("b2b_mul", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12);
    t1 = int'($time);
    run("b2b_div", 3'b011, 32'd9, 32'd2, 32'd1, 32'd4);
    t2 = int'($time);
    chk("b2b.gap_cycles", (t2 - t1) / 10, 32'd35);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
